// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: round-robin arbiter that shares one WIDTH-bit operand
// path between the fetch side (req0) and the execute side (req1). The
// selected word is captured in a one-entry valid/ready output buffer.
// Optional macro ALU_OPERAND_ARBITER_GRANT_CNT_EN adds saturating per-requester
// grant counters; without it the grant_cnt ports read zero.
module alu_operand_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             mux_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_grant_q, last_grant_d;
    logic             mux_sel_q, mux_sel_d;
    logic [WIDTH-1:0] mux_out;
    logic             can_accept, grant0, grant1, grant;

    // Round-robin grant; nothing is accepted in a reset cycle so no
    // handshake completes while state is being discarded.
    always_comb begin
        can_accept = (state_q == EMPTY) || out_ready;
        grant0     = !reset && can_accept && req0_valid && (!req1_valid || last_grant_q);
        grant1     = !reset && can_accept && req1_valid && (!req0_valid || !last_grant_q);
        grant      = grant0 || grant1;
        // Select follows the winner; holds its last value when idle so it never toggles needlessly.
        mux_sel_d  = grant ? grant1 : mux_sel_q;
    end

    // 2:1 operand mux built from 4-bit slices.
    for (genvar g = 0; g < WIDTH / 4; g++) begin : g_slice
        assign mux_out[4*g +: 4] = mux_sel_d ? req1_data[4*g +: 4] : req0_data[4*g +: 4];
    end

    // Buffer FSM and capture of the selected operand.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (!grant && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grant) begin
            out_data_d   = mux_out;
            out_src_d    = mux_sel_d;
            last_grant_d = mux_sel_d;
        end
    end

    // State registers; last_grant resets to 1 so req0 wins first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
            mux_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            mux_sel_q    <= mux_sel_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mux_sel    = mux_sel_d;
    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;

`ifdef ALU_OPERAND_ARBITER_GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating grant counters; they stop at all-ones instead of wrapping.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (grant0 && (grant_cnt0_q != {CNT_W{1'b1}})) grant_cnt0_d = grant_cnt0_q + 1'b1;
        if (grant1 && (grant_cnt1_q != {CNT_W{1'b1}})) grant_cnt1_d = grant_cnt1_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Directed bench for alu_operand_arbiter: reset, single requester, fairness,
// backpressure, reset mid-transfer and the optional grant counters.
module tb_alu_operand_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid, out_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready, mux_sel, out_valid, out_src;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    alu_operand_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 0; req1_valid = 0; out_ready = 0;
        req0_data = '0; req1_data = '0;
        apply_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL rst_out_src got %b exp 0", out_src); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {req0_ready, req1_ready}); end
        checks++; if (mux_sel !== 1'b0) begin errors++; $display("FAIL rst_mux_sel got %b exp 0", mux_sel); end
        checks++; if ({grant_cnt0, grant_cnt1} !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h exp 00", {grant_cnt0, grant_cnt1}); end
    endtask

    task automatic test_single();
        req0_valid = 1; req0_data = 32'h0000_0004; out_ready = 1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'h0000_0004) begin errors++; $display("FAIL single_data got %h exp 00000004", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_src got %b exp 0", out_src); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_fairness();
        logic [WIDTH-1:0] exp_d;
        apply_reset();
        req0_valid = 1; req0_data = 32'hAAAA_AAAA;
        req1_valid = 1; req1_data = 32'h5555_5555;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL fair_ready[%0d] got %b", i, {req0_ready, req1_ready});
            end
            tick();
            exp_d = (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
            checks++;
            if (out_data !== exp_d || out_src !== (i % 2 == 1) || out_valid !== 1'b1) begin
                errors++; $display("FAIL fair_out[%0d] got %h src %b exp %h", i, out_data, out_src, exp_d);
            end
        end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        req0_valid = 1; req0_data = 32'h1234_5678; out_ready = 1;
        tick();
        req0_valid = 0; out_ready = 0;
        req1_valid = 1; req1_data = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req1_ready !== 1'b0 || out_data !== 32'h1234_5678 || out_valid !== 1'b1 || out_src !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got rdy %b data %h valid %b exp 0 12345678 1", i, req1_ready, out_data, out_valid);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++; if (req1_ready !== 1'b1 || mux_sel !== 1'b1) begin errors++; $display("FAIL bp_refill_rdy got %b sel %b exp 1 1", req1_ready, mux_sel); end
        tick();
        req1_valid = 0; out_ready = 0;
        #1;
        checks++; if (out_data !== 32'hCAFE_F00D || out_src !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_refill_data got %h src %b exp cafef00d 1", out_data, out_src); end
        checks++; if (mux_sel !== 1'b1) begin errors++; $display("FAIL bp_sel_hold got %b exp 1", mux_sel); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1; req0_data = 32'h0000_0011; out_ready = 1;
        tick();
        req1_valid = 1; req1_data = 32'h0000_0022;
        reset = 1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rmid_ready got %b exp 00", {req0_ready, req1_ready}); end
        tick();
        reset = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rmid_flush got valid %b data %h exp 0 0", out_valid, out_data); end
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rmid_first got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        checks++; if (out_data !== 32'h0000_0011 || out_src !== 1'b0) begin errors++; $display("FAIL rmid_data got %h exp 00000011", out_data); end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_grant_cnt();
        logic [CNT_W-1:0] exp0;
`ifdef ALU_OPERAND_ARBITER_GRANT_CNT_EN
        exp0 = 4'd15;
`else
        exp0 = 4'd0;
`endif
        apply_reset();
        req0_valid = 1; req0_data = 32'h0000_0001; out_ready = 1;
        repeat (20) tick();
        req0_valid = 0;
        #1;
        checks++; if (grant_cnt0 !== exp0) begin errors++; $display("FAIL cnt0 got %0d exp %0d", grant_cnt0, exp0); end
        checks++; if (grant_cnt1 !== 4'd0) begin errors++; $display("FAIL cnt1 got %0d exp 0", grant_cnt1); end
    endtask

    initial begin
        reset = 1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_grant_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
